// File: rtl/spi_ram_arbiter_pkg.sv
// Command-word encoding and FSM state constants shared by the SPI RAM arbiter slice.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWN     = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  // Address words (cmd[0]==0) keep the grant; cmd[0]==1 ends the transaction.
  function automatic logic cmd_is_addr(input logic [1:0] cmd);
    return ~cmd[0];
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the other requester on update_i.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) grant_o = ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr_q <= 1'b0;
    else if (update_i) ptr_q <= ~last_i;
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates the single-port command RAM between the SPI slave (req0) and host port (req1).
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_valid,
  input  logic [DATA_W+1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_valid,
  output logic [DATA_W+1:0] ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              owner,
  output logic              busy,
  output logic              err
);

  logic [1:0]        st_q, st_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic [DATA_W+1:0] din_q;
  logic              rxv_q;
  logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [1:0]        arb_grant;
  logic              ptr_upd;
  logic              acc0, acc1, acc, rsp_fire, to_hit;
  logic [DATA_W+1:0] acc_word;
  logic [1:0]        acc_cmd;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  ({req1_valid, req0_valid}),
    .update_i (ptr_upd),
    .last_i   (owner_d),
    .grant_o  (arb_grant)
  );

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (st_q)
      ST_IDLE: {req1_ready, req0_ready} = arb_grant;
      ST_OWN: begin
        req0_ready = ~owner_q;
        req1_ready = owner_q;
      end
      default: ;
    endcase
  end

  assign acc0     = req0_valid & req0_ready;
  assign acc1     = req1_valid & req1_ready;
  assign acc      = acc0 | acc1;
  assign acc_word = acc1 ? req1_data : req0_data;
  assign acc_cmd  = acc_word[DATA_W+1:DATA_W];
  assign to_hit   = (cnt_q == TO_W'(TIMEOUT));
  assign rsp_fire = (st_q == ST_WAIT_RD) & ram_tx_valid;

  // Counter defaults to clear; it only advances while waiting with no progress.
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    cnt_d   = '0;
    ptr_upd = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        err_d = ram_tx_valid;
        if (acc) begin
          owner_d = acc1;
          if (cmd_is_addr(acc_cmd))      st_d = ST_OWN;
          else if (acc_cmd == CMD_RD_DATA) st_d = ST_WAIT_RD;
          else                             ptr_upd = 1'b1;
        end
      end
      ST_OWN: begin
        err_d = ram_tx_valid;
        if (acc) begin
          if (acc_cmd == CMD_WR_DATA) begin
            st_d    = ST_IDLE;
            ptr_upd = 1'b1;
          end else if (acc_cmd == CMD_RD_DATA) begin
            st_d = ST_WAIT_RD;
          end
        end else if (to_hit) begin
          st_d    = ST_IDLE;
          err_d   = 1'b1;
          ptr_upd = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_RD: begin
        if (ram_tx_valid) begin
          st_d    = ST_IDLE;
          ptr_upd = 1'b1;
        end else if (to_hit) begin
          st_d    = ST_IDLE;
          err_d   = 1'b1;
          ptr_upd = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      din_q        <= '0;
      rxv_q        <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      rxv_q        <= acc;
      if (acc) din_q <= acc_word;
      rsp0_valid_q <= rsp_fire & ~owner_q;
      rsp1_valid_q <= rsp_fire & owner_q;
      if (rsp_fire & ~owner_q) rsp0_data_q <= ram_dout;
      if (rsp_fire & owner_q)  rsp1_data_q <= ram_dout;
    end
  end

  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;
  assign rsp0_data    = rsp0_data_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_data    = rsp1_data_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign owner        = owner_q;
  assign busy         = (st_q != ST_IDLE);
  assign err          = err_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with hand-computed expectations.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] req0_data, req1_data, ram_din;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] rsp0_data, rsp1_data, ram_dout;
  logic       rsp0_valid, rsp1_valid, ram_rx_valid, ram_tx_valid;
  logic       owner, busy, err;
  logic [63:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.DATA_W(8), .TIMEOUT(255), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .owner(owner), .busy(busy), .err(err)
  );

  assign outs = {30'd0, ram_din, ram_rx_valid, rsp0_data, rsp0_valid, rsp1_data, rsp1_valid,
                 owner, busy, err, req0_ready, req1_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int errs;
    rst_n = 1'b0;
    req0_data = '0; req0_valid = 1'b0;
    req1_data = '0; req1_valid = 1'b0;
    ram_dout = '0; ram_tx_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_outputs", outs, 64'd0);
    tick();

    // Requester 0 write pair
    req0_data = 10'h0A5; req0_valid = 1'b1; #1;
    chk("t1_ready", {62'd0, req1_ready, req0_ready}, 64'd1);
    tick();
    chk("t1_addr_fwd", {53'd0, busy, owner, ram_rx_valid, ram_din}, {53'd0, 1'b1, 1'b0, 1'b1, 10'h0A5});
    req0_data = 10'h13C; #1;
    chk("t1_own_ready", {62'd0, req1_ready, req0_ready}, 64'd1);
    tick();
    chk("t1_data_fwd", {52'd0, busy, ram_rx_valid, ram_din}, {52'd0, 1'b0, 1'b1, 10'h13C});
    req0_valid = 1'b0;
    tick();
    chk("t1_strobe_one_cycle", {63'd0, ram_rx_valid}, 64'd0);

    // Requester 1 read: address then read request, RAM returns 0x3C
    req1_data = 10'h2A5; req1_valid = 1'b1; #1;
    chk("t2_ready", {62'd0, req1_ready, req0_ready}, 64'd2);
    tick();
    req1_data = 10'h300;
    tick();
    req1_valid = 1'b0;
    chk("t2_wait_rd", {52'd0, busy, owner, ram_din}, {52'd0, 1'b1, 1'b1, 10'h300});
    #1;
    chk("t2_wait_no_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    ram_dout = 8'h3C; ram_tx_valid = 1'b1;
    tick();
    ram_tx_valid = 1'b0;
    chk("t2_rsp", {44'd0, rsp1_data, rsp1_valid, rsp0_valid, busy, err, rsp0_data},
        {44'd0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    tick();
    chk("t2_rsp_pulse_hold", {54'd0, rsp1_valid, rsp1_data, rsp0_valid}, {54'd0, 1'b0, 8'h3C, 1'b0});

    // Both valid: order alternates 0,1,0,1
    req0_data = 10'h011; req0_valid = 1'b1;
    req1_data = 10'h033; req1_valid = 1'b1; #1;
    chk("t3_first_grant_r0", {62'd0, req1_ready, req0_ready}, 64'd1);
    tick();
    req0_data = 10'h122;
    tick();
    chk("t3_r0_pair_done", {53'd0, busy, ram_din}, {53'd0, 1'b0, 10'h122});
    req0_data = 10'h011; #1;
    chk("t3_second_grant_r1", {62'd0, req1_ready, req0_ready}, 64'd2);
    tick();
    chk("t3_r1_addr", {53'd0, owner, ram_din}, {53'd0, 1'b1, 10'h033});
    req1_data = 10'h144;
    tick();
    req1_data = 10'h033; #1;
    chk("t3_third_grant_r0", {52'd0, req1_ready, req0_ready, ram_din}, {52'd0, 1'b0, 1'b1, 10'h144});
    tick();
    req0_data = 10'h122;
    tick();
    #1;
    chk("t3_fourth_grant_r1", {62'd0, req1_ready, req0_ready}, 64'd2);
    tick();
    req1_data = 10'h144;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_final", {53'd0, busy, ram_din}, {53'd0, 1'b0, 10'h144});

    // Timeout: req0 addresses and stalls, req1 waits
    req0_data = 10'h010; req0_valid = 1'b1;
    req1_data = 10'h1AB; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    n = 0; errs = 0;
    while (busy && n < 400) begin
      tick();
      n++;
      errs += int'(err);
    end
    chk("t4_timeout_cycles", 64'(n), 64'd256);
    chk("t4_err_once", 64'(errs), 64'd1);
    chk("t4_idle_r1_ready", {61'd0, err, busy, req1_ready}, {61'd0, 1'b1, 1'b0, 1'b1});
    tick();
    req1_valid = 1'b0;
    chk("t4_r1_served", {51'd0, err, ram_rx_valid, owner, ram_din}, {51'd0, 1'b0, 1'b1, 1'b1, 10'h1AB});

    // Stray RAM data in IDLE
    ram_dout = 8'h55; ram_tx_valid = 1'b1;
    tick();
    ram_tx_valid = 1'b0;
    chk("t5_stray", {60'd0, err, rsp0_valid, rsp1_valid, busy}, {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    chk("t5_err_pulse", {63'd0, err}, 64'd0);

    // Reset asserted while waiting for read data
    req0_data = 10'h300; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("t6_wait_rd", {62'd0, busy, ram_rx_valid}, 64'd3);
    rst_n = 1'b0; #1;
    chk("t6_async_clear", outs, 64'd0);
    ram_dout = 8'h77; ram_tx_valid = 1'b1;
    tick();
    tick();
    ram_tx_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t6_post_release", outs, 64'd0);
    req0_data = 10'h0C1; req0_valid = 1'b1;
    tick();
    req0_data = 10'h1D2;
    tick();
    req0_valid = 1'b0;
    chk("t6_new_pair", {52'd0, busy, ram_rx_valid, ram_din}, {52'd0, 1'b0, 1'b1, 10'h1D2});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
